// File: rtl/imem_loader.sv
// Host-to-instruction-memory loader: framed stream (start, count, payload[, checksum]) to external writes.
// Optional readback verification is compiled in with IMEM_LOADER_VERIFY_EN.
`ifndef INSTA_W
`define INSTA_W 8
`endif
`ifndef CPU_W
`define CPU_W 32
`endif
`ifndef DEPTH
`define DEPTH 256
`endif

module imem_loader #(
  parameter int ADDR_W = `INSTA_W,
  parameter int DATA_W = `CPU_W,
  parameter int DEPTH  = `DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_hdata,
  input  logic              i_hvalid,
  output logic              o_hready,
  input  logic              i_abort,
  output logic [ADDR_W-1:0] o_exa,
  output logic [DATA_W-1:0] o_exwd,
  output logic              o_exwe,
  output logic              o_exre,
  input  logic [DATA_W-1:0] i_rd,
  output logic              o_hold,
  output logic              o_done,
  output logic              o_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CNT, S_DATA, S_CHK, S_VRFY, S_DONE, S_ERR
  } state_e;

  // Widened by one bit so a DEPTH equal to 2^DATA_W still compares correctly.
  localparam logic [DATA_W:0] DEPTH_X = (DATA_W+1)'(DEPTH);

  state_e            state_q;
  logic [ADDR_W-1:0] start_q, addr_q, exa_q;
  logic [DATA_W-1:0] cnt_q, k_q, exwd_q;
  logic              exwe_q, done_q, err_q, hold_q, hready_q;
  logic              accept;
  logic              last_k;

  assign accept = i_hvalid && hready_q;
  assign last_k = (k_q + 1'b1) == cnt_q;

`ifdef IMEM_LOADER_VERIFY_EN
  logic [DATA_W-1:0] sum_q, exp_q, rsum_q, rsum_nx;
  logic              exre_q;
  assign rsum_nx = rsum_q + i_rd;
  assign o_exre  = exre_q;
`else
  logic unused_rd;
  assign unused_rd = ^i_rd;
  assign o_exre    = 1'b0;
`endif

  // NOTE: state and outputs are flops, so every update below is non-blocking;
  // blocking assignments here would let later branches see half-updated state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      start_q  <= '0;
      addr_q   <= '0;
      exa_q    <= '0;
      cnt_q    <= '0;
      k_q      <= '0;
      exwd_q   <= '0;
      exwe_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      hold_q   <= 1'b0;
      hready_q <= 1'b1;
`ifdef IMEM_LOADER_VERIFY_EN
      sum_q    <= '0;
      exp_q    <= '0;
      rsum_q   <= '0;
      exre_q   <= 1'b0;
`endif
    end else if (i_abort) begin
      state_q  <= S_IDLE;
      exwe_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      hold_q   <= 1'b0;
      hready_q <= 1'b1;
`ifdef IMEM_LOADER_VERIFY_EN
      exre_q   <= 1'b0;
`endif
    end else begin
      exwe_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            start_q <= i_hdata[ADDR_W-1:0];
            err_q   <= 1'b0;
            hold_q  <= 1'b1;
            state_q <= S_CNT;
          end
        end
        S_CNT: begin
          if (accept) begin
            cnt_q <= i_hdata;
            if ({1'b0, i_hdata} > DEPTH_X) begin
              err_q    <= 1'b1;
              hready_q <= 1'b0;
              state_q  <= S_ERR;
            end else if (i_hdata == '0) begin
`ifdef IMEM_LOADER_VERIFY_EN
              state_q  <= S_CHK;
`else
              done_q   <= 1'b1;
              hready_q <= 1'b0;
              state_q  <= S_DONE;
`endif
            end else begin
              addr_q  <= start_q;
              k_q     <= '0;
`ifdef IMEM_LOADER_VERIFY_EN
              sum_q   <= '0;
`endif
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            exwe_q <= 1'b1;
            exa_q  <= addr_q;
            exwd_q <= i_hdata;
            addr_q <= addr_q + 1'b1;
            k_q    <= k_q + 1'b1;
`ifdef IMEM_LOADER_VERIFY_EN
            sum_q  <= sum_q + i_hdata;
            if (last_k) state_q <= S_CHK;
`else
            if (last_k) begin
              done_q   <= 1'b1;
              hready_q <= 1'b0;
              state_q  <= S_DONE;
            end
`endif
          end
        end
`ifdef IMEM_LOADER_VERIFY_EN
        S_CHK: begin
          if (accept) begin
            exp_q    <= i_hdata;
            rsum_q   <= '0;
            k_q      <= '0;
            hready_q <= 1'b0;
            if (cnt_q == '0) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              exa_q   <= start_q;
              exre_q  <= 1'b1;
              state_q <= S_VRFY;
            end
          end
        end
        S_VRFY: begin
          // i_rd is combinational from o_exa, so it belongs to this cycle's address.
          rsum_q <= rsum_nx;
          exa_q  <= exa_q + 1'b1;
          k_q    <= k_q + 1'b1;
          if (last_k) begin
            exre_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
            if (rsum_nx != sum_q || sum_q != exp_q) err_q <= 1'b1;
          end
        end
`endif
        S_DONE: begin
          hold_q   <= 1'b0;
          hready_q <= 1'b1;
          state_q  <= S_IDLE;
        end
        S_ERR: begin
          hready_q <= 1'b0;
        end
        default: begin
          hold_q   <= 1'b0;
          hready_q <= 1'b1;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign o_hready = hready_q;
  assign o_exa    = exa_q;
  assign o_exwd   = exwd_q;
  assign o_exwe   = exwe_q;
  assign o_hold   = hold_q;
  assign o_done   = done_q;
  assign o_err    = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames from the load protocol plus random frames,
// checked against a frame-level model (expected writes, readback count, done latency, error flag).
module tb_imem_loader;

  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 256;
`ifdef IMEM_LOADER_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] i_hdata = '0;
  logic          i_hvalid = 1'b0;
  logic          o_hready;
  logic          i_abort = 1'b0;
  logic [AW-1:0] o_exa;
  logic [DW-1:0] o_exwd;
  logic          o_exwe, o_exre;
  logic [DW-1:0] i_rd;
  logic          o_hold, o_done, o_err;

  logic [DW-1:0] mem [DEPTH];
  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt = 0, rd_cnt = 0, both_cnt = 0;

  imem_loader #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_hdata(i_hdata), .i_hvalid(i_hvalid), .o_hready(o_hready),
    .i_abort(i_abort), .o_exa(o_exa), .o_exwd(o_exwd), .o_exwe(o_exwe), .o_exre(o_exre),
    .i_rd(i_rd), .o_hold(o_hold), .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  // Instruction memory stand-in: synchronous write, combinational read.
  always @(posedge clk) if (o_exwe) mem[o_exa] <= o_exwd;
  assign i_rd = mem[o_exa];

  always @(negedge clk) begin
    if (o_exwe) wr_cnt <= wr_cnt + 1;
    if (o_exre) rd_cnt <= rd_cnt + 1;
    if (o_exwe && o_exre) both_cnt <= both_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Entered at a negedge; returns at the negedge just after the beat transferred.
  task automatic send(input logic [DW-1:0] d);
    int t = 0;
    i_hvalid = 1'b1;
    i_hdata  = d;
    while (!o_hready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("hready_timeout", 0, 1);
    @(negedge clk);
    i_hvalid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_exa"}, o_exa, 0);
    check({tag, "_exwd"}, o_exwd, 0);
    check({tag, "_exwe"}, o_exwe, 0);
    check({tag, "_exre"}, o_exre, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_err"}, o_err, 0);
    check({tag, "_hold"}, o_hold, 0);
    check({tag, "_hready"}, o_hready, 1);
  endtask

  // One complete frame; rnd selects random payload, otherwise 1,2,3,...
  task automatic run_frame(input logic [AW-1:0] start, input int n, input bit rnd,
                           input bit bad_chk, input bit gaps);
    logic [DW-1:0] d [$];
    logic [DW-1:0] sum = '0;
    logic [AW-1:0] a;
    int w0, r0, lat;
    bit exp_err;
    for (int i = 0; i < n; i++) begin
      d.push_back(rnd ? DW'($urandom) : DW'(i + 1));
      sum += d[i];
    end
    w0 = wr_cnt;
    r0 = rd_cnt;
    send(DW'(start));
    check("hdr_hold", o_hold, 1);
    check("hdr_err_clear", o_err, 0);
    send(DW'(n));
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      send(d[i]);
      a = AW'(int'(start) + i);
      check("wr_en", o_exwe, 1);
      check("wr_addr", o_exa, a);
      check("wr_data", o_exwd, d[i]);
    end
    if (VERIFY) send(bad_chk ? sum + 1 : sum);
    lat = 0;
    while (!o_done && lat < n + 8) begin
      @(negedge clk);
      lat++;
    end
    exp_err = VERIFY && bad_chk && (n > 0);
    check("done_latency", lat, VERIFY ? n : 0);
    check("done_err", o_err, exp_err);
    check("done_hold", o_hold, 1);
    @(negedge clk);
    check("post_done_pulse", o_done, 0);
    check("post_hold", o_hold, 0);
    check("post_hready", o_hready, 1);
    check("post_err_sticky", o_err, exp_err);
    check("write_count", wr_cnt - w0, n);
    check("read_count", rd_cnt - r0, VERIFY ? n : 0);
    for (int i = 0; i < n; i++) check("mem_word", mem[AW'(int'(start) + i)], d[i]);
  endtask

  initial begin
    int w0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    #2 rst = 1'b1;
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_frame(8'h10, 4, 1'b0, 1'b0, 1'b0);
    run_frame(8'h10, 4, 1'b0, 1'b1, 1'b0);
    if (VERIFY) begin
      send(32'h20);
      check("next_hdr_clears_err", o_err, 0);
      i_abort = 1'b1;
      @(negedge clk);
      i_abort = 1'b0;
    end

    run_frame(AW'(DEPTH - 2), 4, 1'b1, 1'b0, 1'b0);
    run_frame(8'h33, 0, 1'b1, 1'b0, 1'b0);

    // Oversized count parks in ERR until abort.
    w0 = wr_cnt;
    send(32'h5);
    send(DW'(DEPTH + 1));
    check("err_hready", o_hready, 0);
    check("err_flag", o_err, 1);
    check("err_hold", o_hold, 1);
    repeat (4) @(negedge clk);
    check("err_still_parked", o_hready, 0);
    check("err_no_writes", wr_cnt - w0, 0);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    check("abort_err_clear", o_err, 0);
    check("abort_hold", o_hold, 0);
    check("abort_hready", o_hready, 1);

    // Largest legal count is accepted and streams into DATA.
    w0 = wr_cnt;
    send(32'h0);
    send(DW'(DEPTH));
    check("max_cnt_no_err", o_err, 0);
    check("max_cnt_hready", o_hready, 1);
    send(32'hABCD);
    check("max_cnt_write", o_exwe, 1);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;

    // Abort after 2 of 5 payload beats.
    w0 = wr_cnt;
    send(32'h40);
    send(32'd5);
    send(32'h111);
    send(32'h222);
    check("abort_mid_last_wr", o_exwe, 1);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    check("abort_mid_exwe", o_exwe, 0);
    check("abort_mid_hold", o_hold, 0);
    check("abort_mid_hready", o_hready, 1);
    check("abort_mid_writes", wr_cnt - w0, 2);
    check("abort_mid_mem", mem[8'h41], 32'h222);

    for (int f = 0; f < 20; f++)
      run_frame(AW'($urandom), int'($urandom_range(1, 9)), 1'b1, 1'($urandom_range(0, 1)), 1'b1);

    // Reset mid-frame (in readback when verify is present, otherwise mid-payload).
    send(32'h80);
    send(32'd4);
    for (int i = 0; i < (VERIFY ? 4 : 2); i++) send(DW'(i + 7));
    if (VERIFY) begin
      send(DW'(7 + 8 + 9 + 10));
      check("vrfy_exre", o_exre, 1);
    end
    #2 rst = 1'b1;
    #1 check_reset_outputs("midframe_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_frame(8'hC0, 3, 1'b1, 1'b0, 1'b0);
    check("never_we_and_re", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
